// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer and its register file.
package apb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACCESS
  } apb_state_e;

  localparam int unsigned WAIT_W = 4;

  // Addresses past the end fail, and so do writes to the read-only ID word at depth-1.
  function automatic logic apb_addr_err(input logic [63:0] addr, input logic write,
                                        input int unsigned depth);
    logic [63:0] d;
    d = 64'(depth);
    return (write && (addr >= (d - 64'd1))) || (addr >= d);
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x N storage with one write port and one combinational read port.
// The top word always reads back as ID_VALUE.
module apb_slave_regfile #(
  parameter int unsigned  N        = 16,
  parameter int unsigned  DEPTH    = 16,
  parameter int unsigned  IDX_W    = $clog2(DEPTH),
  parameter logic [N-1:0] ID_VALUE = 'hA5B0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [N-1:0]     i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [N-1:0]     o_rdata
);

  localparam logic [IDX_W-1:0] IdAddr = IDX_W'(DEPTH - 1);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr == IdAddr) ? ID_VALUE : r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a small register file, with a fixed number of
// wait states per access and pslverr for bad addresses / ID-word writes.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int unsigned  N           = 16,
  parameter int unsigned  ADDR_WIDTH  = 32,
  parameter int unsigned  DEPTH       = 16,
  parameter int unsigned  WAIT_STATES = 0,
  parameter logic [N-1:0] ID_VALUE    = 'hA5B0
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [N-1:0]          pwdata,
  output logic                  pready,
  output logic [N-1:0]          prdata,
  output logic                  pslverr
);

  localparam int unsigned        IdxW   = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WsInit = WAIT_W'(WAIT_STATES);

  if (WAIT_STATES > 15) begin : g_chk_wait
    $error("apb_slave_mem: WAIT_STATES must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("apb_slave_mem: DEPTH must be a power of 2 and at least 2");
  end
  if (ADDR_WIDTH > 64 || ADDR_WIDTH < IdxW) begin : g_chk_addr
    $error("apb_slave_mem: ADDR_WIDTH out of supported range");
  end

  apb_state_e        r_state, w_state_d;
  logic [WAIT_W-1:0] r_cnt, w_cnt_d;
  logic              r_pready, w_pready_d;
  logic              r_pslverr, w_pslverr_d;
  logic [N-1:0]      r_prdata, w_prdata_d;
  logic [IdxW-1:0]   r_addr, w_addr_d;
  logic              r_write, w_write_d;
  logic [N-1:0]      r_wdata, w_wdata_d;
  logic              r_err, w_err_d;

  logic              w_we;
  logic              w_setup_err;
  logic [IdxW-1:0]   w_rd_addr;
  logic [N-1:0]      w_rdata;

  assign w_setup_err = apb_addr_err(64'(paddr), pwrite, DEPTH);

  // In IDLE the read port looks at the live bus so a 0-wait read can load prdata at setup.
  assign w_rd_addr = (r_state == IDLE) ? paddr[IdxW-1:0] : r_addr;

  apb_slave_regfile #(
    .N        (N),
    .DEPTH    (DEPTH),
    .IDX_W    (IdxW),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .i_clk   (pclk),
    .i_rst   (preset),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_pready_d  = 1'b0;
    w_pslverr_d = 1'b0;
    w_prdata_d  = '0;
    w_addr_d    = r_addr;
    w_write_d   = r_write;
    w_wdata_d   = r_wdata;
    w_err_d     = r_err;
    w_we        = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_state_d = ACCESS;
          w_cnt_d   = WsInit;
          w_addr_d  = paddr[IdxW-1:0];
          w_write_d = pwrite;
          w_wdata_d = pwdata;
          w_err_d   = w_setup_err;
          if (WsInit == '0) begin
            w_pready_d  = 1'b1;
            w_pslverr_d = w_setup_err;
            w_prdata_d  = (pwrite || w_setup_err) ? '0 : w_rdata;
          end
        end
      end

      ACCESS: begin
        if (!psel) begin
          w_state_d = IDLE;
        end else if (r_pready) begin
          if (penable) begin
            w_state_d = IDLE;
            w_we      = r_write && !r_err;
          end else begin
            w_pready_d  = 1'b1;
            w_pslverr_d = r_pslverr;
            w_prdata_d  = r_prdata;
          end
        end else begin
          w_cnt_d = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
          if (w_cnt_d == '0) begin
            w_pready_d  = 1'b1;
            w_pslverr_d = r_err;
            w_prdata_d  = (r_write || r_err) ? '0 : w_rdata;
          end
        end
      end

      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_pready  <= w_pready_d;
      r_pslverr <= w_pslverr_d;
      r_prdata  <= w_prdata_d;
      r_addr    <= w_addr_d;
      r_write   <= w_write_d;
      r_wdata   <= w_wdata_d;
      r_err     <= w_err_d;
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 2 and 3 wait states) on a shared
// bus with per-instance psel, checked against an array model of each memory.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [15:0] pwdata;
  logic [2:0]  pready_v;
  logic [2:0]  pslverr_v;
  logic [15:0] prdata_v [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mdl [3][16];

  always #5 pclk = ~pclk;

  apb_slave_mem #(.N(16), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(0), .ID_VALUE(16'hA5B0))
  u_dut0 (.pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
          .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]), .prdata(prdata_v[0]),
          .pslverr(pslverr_v[0]));

  apb_slave_mem #(.N(16), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(2), .ID_VALUE(16'hA5B0))
  u_dut1 (.pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
          .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]), .prdata(prdata_v[1]),
          .pslverr(pslverr_v[1]));

  apb_slave_mem #(.N(16), .ADDR_WIDTH(32), .DEPTH(16), .WAIT_STATES(3), .ID_VALUE(16'hA5B0))
  u_dut2 (.pclk(pclk), .preset(preset), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
          .paddr(paddr), .pwdata(pwdata), .pready(pready_v[2]), .prdata(prdata_v[2]),
          .pslverr(pslverr_v[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic bit exp_err(input bit wr, input logic [31:0] a);
    return (a >= 32'd16) || (wr && a == 32'd15);
  endfunction

  function automatic logic [15:0] exp_rd(input int d, input logic [31:0] a);
    if (a >= 32'd16) return 16'h0000;
    if (a == 32'd15) return 16'hA5B0;
    return mdl[d][a[3:0]];
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 16; i++) mdl[d][i] = 16'h0000;
  endtask

  task automatic model_wr(input int d, input logic [31:0] a, input logic [15:0] wd);
    if (!exp_err(1'b1, a)) mdl[d][a[3:0]] = wd;
  endtask

  // One full transfer; returns at the negedge of the completion cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [15:0] wd,
                      output logic [15:0] rd, output logic er, output int waits,
                      output bit viol);
    @(negedge pclk);
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = $urandom;
    pwdata  = 16'($urandom);
    waits   = 0;
    viol    = 1'b0;
    while (pready_v[d] !== 1'b1 && waits < 40) begin
      if (pslverr_v[d] !== 1'b0) viol = 1'b1;
      waits++;
      @(negedge pclk);
    end
    if (waits >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL xfer_timeout: dut%0d pready never rose (got %b, expected 1)", d,
               pready_v[d]);
    end
    rd = prdata_v[d];
    er = pslverr_v[d];
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    preset = 1'b1;
    model_clear();
    repeat (2) @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      n_chk++;
      if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prdata_v[d] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state: dut%0d got rdy=%b err=%b rd=%h expected 0/0/0000", d,
                 pready_v[d], pslverr_v[d], prdata_v[d]);
      end
    end
    preset = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_basic_rw();
    logic [15:0] rd; logic er; int w; bit v;
    xfer(0, 1'b1, 32'd3, 16'h1234, rd, er, w, v);
    model_wr(0, 32'd3, 16'h1234);
    n_chk++;
    if (er !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL basic_write: got err=%b waits=%0d expected err=0 waits=0", er, w);
    end
    bus_idle();
    n_chk++;
    if (pready_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pready_drop: got %b expected 0", pready_v[0]);
    end
    xfer(0, 1'b0, 32'd3, 16'h0, rd, er, w, v);
    n_chk++;
    if (rd !== 16'h1234 || er !== 1'b0 || w != 0) begin
      n_fail++;
      $display("FAIL basic_read: got rd=%h err=%b waits=%0d expected 1234/0/0", rd, er, w);
    end
    bus_idle();
  endtask

  task automatic test_wait_states();
    logic [15:0] rd; logic er; int w; bit v;
    xfer(2, 1'b0, 32'd5, 16'h0, rd, er, w, v);
    n_chk++;
    if (w != 3 || rd !== 16'h0 || er !== 1'b0 || v) begin
      n_fail++;
      $display("FAIL wait3_read: got waits=%0d rd=%h err=%b viol=%b expected 3/0000/0/0",
               w, rd, er, v);
    end
    bus_idle();
  endtask

  task automatic test_id_word();
    logic [15:0] rd; logic er; int w; bit v;
    xfer(0, 1'b1, 32'd15, 16'hFFFF, rd, er, w, v);
    model_wr(0, 32'd15, 16'hFFFF);
    n_chk++;
    if (er !== 1'b1) begin
      n_fail++;
      $display("FAIL id_write_err: got %b expected 1", er);
    end
    xfer(0, 1'b0, 32'd15, 16'h0, rd, er, w, v);
    n_chk++;
    if (rd !== exp_rd(0, 32'd15) || er !== 1'b0) begin
      n_fail++;
      $display("FAIL id_read: got rd=%h err=%b expected %h/0", rd, er, exp_rd(0, 32'd15));
    end
    bus_idle();
  endtask

  task automatic test_range_err();
    logic [15:0] rd; logic er; int w; bit v;
    xfer(1, 1'b0, 32'd16, 16'h0, rd, er, w, v);
    n_chk++;
    if (er !== 1'b1 || rd !== 16'h0 || w != 2) begin
      n_fail++;
      $display("FAIL range_read: got err=%b rd=%h waits=%0d expected 1/0000/2", er, rd, w);
    end
    xfer(1, 1'b1, 32'd100, 16'h0BAD, rd, er, w, v);
    model_wr(1, 32'd100, 16'h0BAD);
    n_chk++;
    if (er !== 1'b1) begin
      n_fail++;
      $display("FAIL range_write: got err=%b expected 1", er);
    end
    for (int a = 0; a < 16; a++) begin
      xfer(1, 1'b0, 32'(a), 16'h0, rd, er, w, v);
      n_chk++;
      if (rd !== exp_rd(1, 32'(a)) || er !== 1'b0) begin
        n_fail++;
        $display("FAIL readback[%0d]: got rd=%h err=%b expected %h/0", a, rd, er,
                 exp_rd(1, 32'(a)));
      end
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd, wd; logic er; int w, d; bit v, wr; logic [31:0] a;
    for (int k = 0; k < 60; k++) begin
      d  = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 14));
      wd = 16'($urandom);
      xfer(d, wr, a, wd, rd, er, w, v);
      n_chk++;
      if (er !== exp_err(wr, a) || w != ws_of(d) || v || (!wr && rd !== exp_rd(d, a))) begin
        n_fail++;
        $display("FAIL b2b[%0d]: dut%0d wr=%b a=%0d got rd=%h err=%b waits=%0d expected %h/%b/%0d",
                 k, d, wr, a, rd, er, w, exp_rd(d, a), exp_err(wr, a), ws_of(d));
      end
      if (wr) model_wr(d, a, wd);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [15:0] rd, wd; logic er; int w; bit v, late;
    wd = ~mdl[2][7];
    @(negedge pclk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'd7; pwdata = wd;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 3'b000; penable = 1'b0;
    @(negedge pclk);
    n_chk++;
    if (pready_v[2] !== 1'b0 || pslverr_v[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rdy=%b err=%b expected 0/0", pready_v[2], pslverr_v[2]);
    end
    late = 1'b0;
    repeat (5) begin
      @(negedge pclk);
      if (pready_v[2] !== 1'b0) late = 1'b1;
    end
    n_chk++;
    if (late) begin
      n_fail++;
      $display("FAIL abort_late_ready: got pready=1 after abort expected 0");
    end
    xfer(2, 1'b0, 32'd7, 16'h0, rd, er, w, v);
    n_chk++;
    if (rd !== mdl[2][7] || er !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_commit: got rd=%h err=%b expected %h/0", rd, er, mdl[2][7]);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic er; int w; bit v;
    xfer(1, 1'b1, 32'd2, 16'h5555, rd, er, w, v);
    model_wr(1, 32'd2, 16'h5555);
    // dut0 (0 waits) is ready when reset strikes; dut1 is mid-wait.
    @(negedge pclk);
    psel = 3'b011; penable = 1'b0; pwrite = 1'b1; paddr = 32'd2; pwdata = 16'h7777;
    @(negedge pclk);
    penable = 1'b1;
    n_chk++;
    if (pready_v[0] !== 1'b1 || pready_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_ready: got rdy0=%b rdy1=%b expected 1/0", pready_v[0],
               pready_v[1]);
    end
    #2 preset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (pready_v[d] !== 1'b0 || pslverr_v[d] !== 1'b0 || prdata_v[d] !== 16'h0) begin
        n_fail++;
        $display("FAIL async_reset: dut%0d got rdy=%b err=%b rd=%h expected 0/0/0000", d,
                 pready_v[d], pslverr_v[d], prdata_v[d]);
      end
    end
    @(negedge pclk);
    psel = 3'b000; penable = 1'b0;
    preset = 1'b0;
    model_clear();
    xfer(1, 1'b0, 32'd2, 16'h0, rd, er, w, v);
    n_chk++;
    if (rd !== exp_rd(1, 32'd2) || er !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cleared_a2: got rd=%h err=%b expected %h/0", rd, er,
               exp_rd(1, 32'd2));
    end
    xfer(0, 1'b0, 32'd3, 16'h0, rd, er, w, v);
    n_chk++;
    if (rd !== exp_rd(0, 32'd3) || er !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cleared_a3: got rd=%h err=%b expected %h/0", rd, er,
               exp_rd(0, 32'd3));
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_wait_states();
    test_id_word();
    test_range_err();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
